// File: rtl/bist_pkg.sv
// Shared types and defaults for the BIST pattern generator / signature compactor.
package bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_t;

  localparam logic [7:0] DEF_LFSR_SEED = 8'h01;
  localparam logic [7:0] DEF_LFSR_POLY = 8'hB8;
  localparam logic [7:0] DEF_MISR_POLY = 8'hB8;
  localparam int         CNT_W         = 16;

endpackage

// File: rtl/bist_lfsr_misr_galois_step.sv
// One shift of a right-shifting Galois register: the feedback mask is applied when bit 0 falls out.
// Purely combinational; shared by the pattern LFSR and the response MISR.
module galois_step #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = 8'hB8
) (
  input  logic [WIDTH-1:0] i_x,
  output logic [WIDTH-1:0] o_y
);

  assign o_y = i_x[0] ? ((i_x >> 1) ^ POLY) : (i_x >> 1);

endmodule

// File: rtl/bist_lfsr_misr.sv
// BIST datapath: LFSR pattern source, MISR response compactor, pass/fail judgement one cycle after finish.
// BIST_PATTERN_COUNT_EN adds a saturating pattern counter and an optional expected-count check on pass.
module bist_lfsr_misr
  import bist_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] LFSR_SEED  = DEF_LFSR_SEED,
  parameter logic [WIDTH-1:0] LFSR_POLY  = DEF_LFSR_POLY,
  parameter logic [WIDTH-1:0] MISR_POLY  = DEF_MISR_POLY,
`ifdef BIST_PATTERN_COUNT_EN
  parameter logic [WIDTH-1:0] GOLDEN_SIG = '0,
  parameter logic [CNT_W-1:0] EXP_PATTERNS = '0
`else
  parameter logic [WIDTH-1:0] GOLDEN_SIG = '0
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             init,
  input  logic             running,
  input  logic             mode,
  input  logic             finish,
  input  logic [WIDTH-1:0] dut_response,
  output logic [WIDTH-1:0] pattern,
  output logic [WIDTH-1:0] signature,
  output logic             sig_valid,
  output logic             pass,
`ifdef BIST_PATTERN_COUNT_EN
  output logic             fail,
  output logic [CNT_W-1:0] pattern_count
`else
  output logic             fail
`endif
);

  bist_state_t      r_state;
  logic [WIDTH-1:0] r_lfsr;
  logic [WIDTH-1:0] r_misr;
  logic             r_valid;
  logic             r_pass;
  logic             r_fail;
  logic [WIDTH-1:0] w_lfsr_next;
  logic [WIDTH-1:0] w_misr_shift;
  logic             w_capture;
  logic             w_verdict;

  galois_step #(.WIDTH(WIDTH), .POLY(LFSR_POLY)) u_lfsr_step (
    .i_x (r_lfsr),
    .o_y (w_lfsr_next)
  );

  galois_step #(.WIDTH(WIDTH), .POLY(MISR_POLY)) u_misr_step (
    .i_x (r_misr),
    .o_y (w_misr_shift)
  );

  assign w_capture = running && mode;

`ifdef BIST_PATTERN_COUNT_EN
  logic [CNT_W-1:0] r_cnt;

  // A zero expected count means "don't care about the count".
  assign w_verdict = (r_misr == GOLDEN_SIG) &&
                     ((EXP_PATTERNS == '0) || (r_cnt == EXP_PATTERNS));
  assign pattern_count = r_cnt;

  always_ff @(posedge clock) begin
    if (reset || init) begin
      r_cnt <= '0;
    end else if ((r_state == ST_ARMED || r_state == ST_RUN) && !finish && w_capture
                 && r_cnt != {CNT_W{1'b1}}) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_verdict = (r_misr == GOLDEN_SIG);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_lfsr  <= LFSR_SEED;
      r_misr  <= '0;
      r_valid <= 1'b0;
      r_pass  <= 1'b0;
      r_fail  <= 1'b0;
    end else if (init) begin
      // init beats a coincident finish, so no result is produced that cycle.
      r_state <= ST_ARMED;
      r_lfsr  <= LFSR_SEED;
      r_misr  <= '0;
      r_valid <= 1'b0;
      r_pass  <= 1'b0;
      r_fail  <= 1'b0;
    end else begin
      case (r_state)
        ST_ARMED, ST_RUN: begin
          if (finish) begin
            r_state <= ST_DONE;
            r_valid <= 1'b1;
            r_pass  <= w_verdict;
            r_fail  <= !w_verdict;
          end else if (w_capture) begin
            r_state <= ST_RUN;
            r_lfsr  <= w_lfsr_next;
            r_misr  <= w_misr_shift ^ dut_response;
          end
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

  assign pattern   = r_lfsr;
  assign signature = r_misr;
  assign sig_valid = r_valid;
  assign pass      = r_pass;
  assign fail      = r_fail;

endmodule
